cfg_rr_arbiter_hold: RTL and testbench
======================================

// Module: cfg_rr_arbiter_hold
// PURPOSE
//   Parametrised N-way bus arbiter with run-time selectable fixed-priority or round-robin mode.
//   Adds optional grant hold (owner keeps the bus while requesting) bounded by a hold timeout.
//   Also provides an encoded grant index.
//   Sits between N bus masters and the shared bus mux; gnt_idx drives the mux select directly.
// PARAMETERS
//   N         4   number of requesters, legal 2..16
//   MAX_HOLD  8   max consecutive cycles one owner may hold a grant when hold_en=1, legal 1..255
//   IDX_W     $clog2(N)  localparam, width of gnt_idx and last-winner pointer
//   CNT_W     $clog2(MAX_HOLD+1)  localparam, width of hold counter
// PORTS
//   clk        in   1      system clock, all state on rising edge
//   rst        in   1      asynchronous, active-high reset
//   req        in   N      request vector, bit i = master i
//   mode       in   1      0 = fixed priority (bit 0 highest), 1 = round robin
//   hold_en    in   1      1 = owner keeps grant while req[owner] high (bounded by MAX_HOLD)
//   gnt        out  N      one-hot grant, registered
//   gnt_valid  out  1      |gnt, registered
//   gnt_idx    out  IDX_W  binary index of granted master; 0 when gnt_valid=0
//   timeout    out  1      one-cycle pulse: previous owner was forcibly released
// BEHAVIOUR
//   Reset (async, immediate):
//     gnt=0, gnt_valid=0, gnt_idx=0, timeout=0, state=IDLE, hold_cnt=0, last=N-1
//     (master 0 wins first RR arbitration).
//   Latency: req sampled at edge k -> gnt valid after edge k; one cycle, no combinational req->gnt path.
//   Arbitration function ARB(vec):
//     mode=0: lowest set index wins.
//     mode=1: search last+1, last+2, ... modulo N.
//     vec==0 -> no grant.
//   last <= winner index on every new grant, in BOTH modes, so a mode switch stays fair.
//   States: IDLE (no grant), OWN (grant to owner = gnt_idx).
//   IDLE: any req -> gnt <= onehot(ARB(req)), hold_cnt <= 1, go OWN. Else stay IDLE, outputs 0.
//   OWN, hold_en=0: re-arbitrate every cycle with ARB(req), hold_cnt <= 1.
//     req==0 -> IDLE.
//     The same master may win consecutively. No timeout is ever raised.
//   OWN, hold_en=1:
//     - req[owner]=1 and hold_cnt<MAX_HOLD: keep gnt, hold_cnt++, last unchanged.
//     - req[owner]=0: new grant = ARB(req), or IDLE if req==0. hold_cnt <= 1.
//     - req[owner]=1 and hold_cnt==MAX_HOLD: forced release; timeout <= 1 for one cycle.
//       New grant = ARB(req & ~onehot(owner)).
//       If only the owner requests, it is regranted with hold_cnt <= 1.
//     - Owner therefore holds at most MAX_HOLD consecutive cycles while others wait.
//   Mode or hold_en changes take effect at the next edge. A held grant under hold_en=1
//     is not broken by a mode change. Dropping hold_en mid-hold re-arbitrates at the next edge.
//   Simultaneous owner release + timeout cannot occur: release takes precedence, no timeout pulse.
//   gnt always one-hot or zero; gnt_idx consistent with gnt in the same cycle.
//   Grants never go to a master whose req was 0 at the sampling edge.
// TESTING
//   1 mode=0, hold_en=0, req=4'b1010 -> gnt=4'b0010, gnt_idx=1; then req=4'b1111 -> gnt=4'b0001.
//   2 after reset, mode=1, hold_en=0, req=4'b1111 steady -> gnt 0001,0010,0100,1000,0001 on successive cycles.
//   3 mode=1, hold_en=1, MAX_HOLD=4, req=4'b0011 steady:
//       gnt=0001 for 4 cycles, then gnt=0010 with timeout=1 for 1 cycle;
//       0010 held 4 cycles, then back to 0001.
//   4 hold_en=1, owner 2 holding, req[0]=1 throughout; req[2] drops at cycle 2 ->
//       gnt=0001 the following cycle, timeout stays 0.
//   5 mode=0, hold_en=1, MAX_HOLD=4, req=4'b0001 only ->
//       timeout pulses every 4 cycles, gnt stays 0001, never 0.
//   6 assert rst mid-hold (between edges) -> gnt/gnt_valid/gnt_idx=0 immediately;
//       release, mode=1, req=4'b1111 -> first gnt=0001.

Source files
------------

// File: rtl/cfg_rr_arbiter_hold.sv
// N-way bus arbiter: fixed-priority or round-robin per cycle, with optional
// bounded grant hold. Grant, index and timeout are all registered outputs.
module cfg_rr_arbiter_hold #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 mode,
  input  logic                 hold_en,
  output logic [N-1:0]         gnt,
  output logic                 gnt_valid,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 timeout
);
  localparam int IDX_W = $clog2(N);
  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [IDX_W-1:0]   idx_d, arb_idx;
  logic [N-1:0]       gnt_d, arb_vec;
  logic               vld_d, to_d, arb_hit;
  logic               keep, expire;

  // Owner still requesting with hold enabled; expire when its budget is spent.
  assign keep    = (state_q == OWN) && hold_en && req[gnt_idx];
  assign expire  = keep && (cnt_q == CNT_W'(MAX_HOLD));
  assign arb_vec = expire ? (req & ~gnt) : req;

  // Descending scan so the last hit is the highest-priority candidate.
  always_comb begin
    int               j;
    logic [IDX_W-1:0] jj;
    arb_hit = 1'b0;
    arb_idx = '0;
    j       = 0;
    jj      = '0;
    for (int k = N; k >= 1; k--) begin
      if (mode) j = (int'(last_q) + k) % N;
      else      j = k - 1;
      jj = IDX_W'(j);
      if (arb_vec[jj]) begin
        arb_hit = 1'b1;
        arb_idx = jj;
      end
    end
  end

  always_comb begin
    state_d = IDLE;
    vld_d   = 1'b0;
    idx_d   = '0;
    cnt_d   = '0;
    last_d  = last_q;
    to_d    = expire;
    if (keep && !expire) begin
      state_d = OWN;
      vld_d   = 1'b1;
      idx_d   = gnt_idx;
      cnt_d   = cnt_q + CNT_W'(1);
    end else if (arb_hit) begin
      state_d = OWN;
      vld_d   = 1'b1;
      idx_d   = arb_idx;
      cnt_d   = CNT_W'(1);
      last_d  = arb_idx;
    end else if (expire) begin
      // Sole requester timed out: regrant it with a fresh budget.
      state_d = OWN;
      vld_d   = 1'b1;
      idx_d   = gnt_idx;
      cnt_d   = CNT_W'(1);
      last_d  = gnt_idx;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_dec
    assign gnt_d[i] = vld_d && (idx_d == IDX_W'(i));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= IDX_W'(N - 1);
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_idx   <= '0;
      timeout   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      gnt       <= gnt_d;
      gnt_valid <= vld_d;
      gnt_idx   <= idx_d;
      timeout   <= to_d;
    end
  end
endmodule

// File: tb/tb_cfg_rr_arbiter_hold.sv
// Directed bench for cfg_rr_arbiter_hold (N=4, MAX_HOLD=4).
module tb_cfg_rr_arbiter_hold;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       mode, hold_en;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_idx;
  logic       timeout;

  int n_cmp = 0;
  int n_err = 0;

  cfg_rr_arbiter_hold #(.N(4), .MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst), .req(req), .mode(mode), .hold_en(hold_en),
    .gnt(gnt), .gnt_valid(gnt_valid), .gnt_idx(gnt_idx), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  logic [3:0] rr_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [1:0] rr_idx [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [3:0] h_gnt  [9] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001,
                             4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0001};
  logic       h_to   [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    rst = 1'b1; req = '0; mode = 1'b0; hold_en = 1'b0;
    #12;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_valid", 32'(gnt_valid), 32'h0);
    chk("rst_idx", 32'(gnt_idx), 32'h0);
    chk("rst_timeout", 32'(timeout), 32'h0);
    rst = 1'b0;

    // Fixed priority
    req = 4'b1010;
    tick();
    chk("fp_gnt_a", 32'(gnt), 32'h2);
    chk("fp_idx_a", 32'(gnt_idx), 32'h1);
    chk("fp_valid_a", 32'(gnt_valid), 32'h1);
    req = 4'b1111;
    tick();
    chk("fp_gnt_b", 32'(gnt), 32'h1);
    chk("fp_idx_b", 32'(gnt_idx), 32'h0);
    req = 4'b0000;
    tick();
    chk("idle_gnt", 32'(gnt), 32'h0);
    chk("idle_valid", 32'(gnt_valid), 32'h0);

    // Round robin rotation from reset
    pulse_rst();
    mode = 1'b1; req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("rr_gnt_%0d", i), 32'(gnt), 32'(rr_gnt[i]));
      chk($sformatf("rr_idx_%0d", i), 32'(gnt_idx), 32'(rr_idx[i]));
      chk($sformatf("rr_to_%0d", i), 32'(timeout), 32'h0);
    end

    // Hold with timeout, two requesters
    req = 4'b0000;
    pulse_rst();
    mode = 1'b1; hold_en = 1'b1; req = 4'b0011;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk($sformatf("hold_gnt_%0d", i), 32'(gnt), 32'(h_gnt[i]));
      chk($sformatf("hold_to_%0d", i), 32'(timeout), 32'(h_to[i]));
    end

    // Owner 2 releases while master 0 waits: no timeout
    req = 4'b0000;
    pulse_rst();
    mode = 1'b1; hold_en = 1'b1; req = 4'b0100;
    tick();
    chk("rel_gnt_0", 32'(gnt), 32'h4);
    req = 4'b0101;
    tick();
    chk("rel_gnt_1", 32'(gnt), 32'h4);
    req = 4'b0001;
    tick();
    chk("rel_gnt_2", 32'(gnt), 32'h1);
    chk("rel_to_2", 32'(timeout), 32'h0);

    // Sole requester: periodic timeout, never loses grant
    req = 4'b0000;
    pulse_rst();
    mode = 1'b0; hold_en = 1'b1; req = 4'b0001;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk($sformatf("solo_gnt_%0d", i), 32'(gnt), 32'h1);
      chk($sformatf("solo_to_%0d", i), 32'(timeout), 32'((i == 4) || (i == 8)));
    end

    // Async reset mid-hold
    #2;
    rst = 1'b1;
    #1;
    chk("arst_gnt", 32'(gnt), 32'h0);
    chk("arst_valid", 32'(gnt_valid), 32'h0);
    chk("arst_idx", 32'(gnt_idx), 32'h0);
    rst = 1'b0;
    mode = 1'b1; hold_en = 1'b0; req = 4'b1111;
    tick();
    chk("arst_first_gnt", 32'(gnt), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
